// File: rtl/vga_write_arbiter.sv
// Merges drawer pixels (via a FIFO) and a rectangular background-clear sweep into
// one registered adapter write stream. Define VGA_ARB_CLIP_EN to drop off-screen drawer pixels.
module vga_write_arbiter #(
  parameter int unsigned CLR_X0    = 0,
  parameter int unsigned CLR_Y0    = 0,
  parameter int unsigned CLR_W     = 160,
  parameter int unsigned CLR_H     = 120,
  parameter logic [2:0]  BG_COLOUR = 3'b000,
  parameter int unsigned FIFO_AW   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_req,
  input  logic       in_we,
  input  logic [7:0] in_x,
  input  logic [6:0] in_y,
  input  logic [2:0] in_colour,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CXW   = (CLR_W > 1) ? $clog2(CLR_W) : 1;
  localparam int unsigned CYW   = (CLR_H > 1) ? $clog2(CLR_H) : 1;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [CXW-1:0]   CX_LAST  = CXW'(CLR_W - 1);
  localparam logic [CYW-1:0]   CY_LAST  = CYW'(CLR_H - 1);

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

  typedef enum logic {IDLE, CLEAR} state_t;

  // Rectangle must fit the 160x120 screen; there is no runtime wrap.
  if (CLR_W < 1 || CLR_H < 1 || CLR_X0 + CLR_W > 160 || CLR_Y0 + CLR_H > 120) begin : g_bad_rect
    $error("vga_write_arbiter: clear rectangle does not fit the screen");
  end

  state_t               state_q, state_d;
  logic [CXW-1:0]       cx_q, cx_d;
  logic [CYW-1:0]       cy_q, cy_d;

  pixel_t               mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_AW:0]     count;
  logic                 fifo_empty, fifo_full;

  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_clear_q, s1_clear_d;
  pixel_t               s1_pix_q, s1_pix_d;

  pixel_t               in_pix;
  logic                 in_range, push_ok, push, pop, drop;

  assign in_pix     = '{x: in_x, y: in_y, colour: in_colour};
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);

`ifdef VGA_ARB_CLIP_EN
  assign in_range = (in_x < 8'd160) && (in_y < 7'd120);
`else
  assign in_range = 1'b1;
`endif

  // Pixels arriving with a clear request are discarded: the sweep covers them.
  assign push_ok = in_we && !clr_req && in_range;
  assign push    = push_ok && (!fifo_full || pop);
  assign drop    = push_ok && fifo_full && !pop;

  // Next state, sweep counters and selection of the pixel entering the output pipe.
  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    pop        = 1'b0;
    s1_valid_d = 1'b0;
    s1_clear_d = 1'b0;
    s1_pix_d   = s1_pix_q;
    if (clr_req) begin
      state_d = CLEAR;
      cx_d    = '0;
      cy_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            s1_valid_d = 1'b1;
            s1_pix_d   = mem[rd_ptr];
          end
        end
        CLEAR: begin
          s1_valid_d = 1'b1;
          s1_clear_d = 1'b1;
          s1_pix_d   = '{x: 8'(CLR_X0) + 8'(cx_q),
                         y: 7'(CLR_Y0) + 7'(cy_q),
                         colour: BG_COLOUR};
          if (cx_q == CX_LAST) begin
            cx_d = '0;
            if (cy_q == CY_LAST) begin
              cy_d    = '0;
              state_d = IDLE;
            end else begin
              cy_d = cy_q + CYW'(1);
            end
          end else begin
            cx_d = cx_q + CXW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_pix;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cx_q       <= '0;
      cy_q       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      s1_valid_q <= 1'b0;
      s1_clear_q <= 1'b0;
      s1_pix_q   <= '0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      s1_valid_q <= s1_valid_d;
      s1_clear_q <= s1_clear_d;
      s1_pix_q   <= s1_pix_d;
      x          <= s1_pix_q.x;
      y          <= s1_pix_q.y;
      colour     <= s1_pix_q.colour;
      plot       <= s1_valid_q;
      busy       <= s1_clear_q;
      if (drop) overflow <= 1'b1;
      if (clr_req) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
        if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
        case ({push, pop})
          2'b10:   count <= count + (FIFO_AW + 1)'(1);
          2'b01:   count <= count - (FIFO_AW + 1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Bench for vga_write_arbiter: directed table, hand-written sweep sequences and
// randomized traffic checked against a queue-based reference model.
module tb_vga_write_arbiter;

  localparam int unsigned X0 = 10;
  localparam int unsigned Y0 = 20;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 3;
  localparam logic [2:0]  BG = 3'b001;
  localparam int unsigned AW = 2;
  localparam int unsigned DEPTH = 1 << AW;
`ifdef VGA_ARB_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    logic clr;
    logic we;
    pix_t p;
    logic e_plot;
    pix_t e_pix;
    logic e_busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clr_req = 1'b0;
  logic       in_we = 1'b0;
  logic [7:0] in_x = '0;
  logic [6:0] in_y = '0;
  logic [2:0] in_colour = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, overflow;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  vga_write_arbiter #(
    .CLR_X0(X0), .CLR_Y0(Y0), .CLR_W(W), .CLR_H(H), .BG_COLOUR(BG), .FIFO_AW(AW)
  ) dut (
    .clk(clk), .reset(reset), .clr_req(clr_req), .in_we(in_we),
    .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: queues of pending drawer pixels and remaining sweep pixels,
  // plus the two-cycle output delay.
  pix_t m_fifo[$];
  pix_t m_sweep[$];
  logic m_s1_v = 1'b0, m_s1_b = 1'b0, m_out_v = 1'b0, m_out_b = 1'b0, m_ovf = 1'b0;
  pix_t m_s1 = '0, m_out = '0;

  pix_t got[$];
  int   got_first, got_last, got_busy;

  function automatic pix_t mk(input int px, input int py, input int pc);
    pix_t p;
    p.x = 8'(px);
    p.y = 7'(py);
    p.c = 3'(pc);
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic cl, input logic we, input pix_t p);
    logic sel_v, sel_b, keep;
    pix_t sel;
    sel_v = 1'b0;
    sel_b = 1'b0;
    sel   = m_s1;
    keep  = !CLIP || (p.x < 8'd160 && p.y < 7'd120);
    if (r) begin
      m_fifo.delete();
      m_sweep.delete();
      m_s1_v = 0; m_s1_b = 0; m_s1 = '0;
      m_out_v = 0; m_out_b = 0; m_out = '0;
      m_ovf = 0;
    end else begin
      m_out_v = m_s1_v;
      m_out_b = m_s1_b;
      m_out   = m_s1;
      if (cl) begin
        m_fifo.delete();
        m_sweep.delete();
        for (int ry = 0; ry < int'(H); ry++)
          for (int rx = 0; rx < int'(W); rx++)
            m_sweep.push_back(mk(int'(X0) + rx, int'(Y0) + ry, int'(BG)));
      end else begin
        if (m_sweep.size() > 0) begin
          sel = m_sweep.pop_front(); sel_v = 1; sel_b = 1;
        end else if (m_fifo.size() > 0) begin
          sel = m_fifo.pop_front(); sel_v = 1;
        end
        if (we && keep) begin
          if (m_fifo.size() < DEPTH) m_fifo.push_back(p);
          else m_ovf = 1;
        end
      end
      m_s1_v = sel_v;
      m_s1_b = sel_b;
      m_s1   = sel;
    end
  endtask

  task automatic step(input logic r, input logic cl, input logic we, input pix_t p);
    @(negedge clk);
    reset = r; clr_req = cl; in_we = we;
    in_x = p.x; in_y = p.y; in_colour = p.c;
    @(posedge clk);
    model_edge(r, cl, we, p);
    #1;
    cyc++;
    chk("plot", 32'(plot), 32'(m_out_v));
    chk("busy", 32'(busy), 32'(m_out_b));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (m_out_v || r) begin
      chk("x", 32'(x), 32'(m_out.x));
      chk("y", 32'(y), 32'(m_out.y));
      chk("colour", 32'(colour), 32'(m_out.c));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0);
  endtask

  task automatic cstep(input logic cl, input logic we, input pix_t p);
    step(0, cl, we, p);
    if (plot) begin
      got.push_back(mk(int'(x), int'(y), int'(colour)));
      if (got_first < 0) got_first = cyc;
      got_last = cyc;
      if (busy) got_busy++;
    end
  endtask

  task automatic clear_got();
    got.delete();
    got_first = -1;
    got_last  = -1;
    got_busy  = 0;
  endtask

  task automatic chk_seq(input string name, input pix_t exp[$]);
    chk({name, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk({name, "_pix"}, 32'(got[i]), 32'(exp[i]));
  endtask

  function automatic void add_sweep(inout pix_t q[$]);
    for (int ry = 0; ry < int'(H); ry++)
      for (int rx = 0; rx < int'(W); rx++)
        q.push_back(mk(int'(X0) + rx, int'(Y0) + ry, int'(BG)));
  endfunction

  vec_t tv[12];
  pix_t expq[$];

  initial begin
    // Directed table: pass-through, clip pair, and start of a sweep.
    tv[0]  = '{0, 1, mk(5, 7, 4),   0, '0, 0};
    tv[1]  = '{0, 0, '0,            0, '0, 0};
    tv[2]  = '{0, 0, '0,            1, mk(5, 7, 4), 0};
    tv[3]  = '{0, 0, '0,            0, '0, 0};
    tv[4]  = '{0, 1, mk(170, 5, 2), 0, '0, 0};
    tv[5]  = '{0, 1, mk(3, 4, 5),   0, '0, 0};
    tv[6]  = '{0, 0, '0,            !CLIP, mk(170, 5, 2), 0};
    tv[7]  = '{0, 0, '0,            1, mk(3, 4, 5), 0};
    tv[8]  = '{0, 0, '0,            0, '0, 0};
    tv[9]  = '{1, 0, '0,            0, '0, 0};
    tv[10] = '{0, 0, '0,            0, '0, 0};
    tv[11] = '{0, 0, '0,            1, mk(X0, Y0, BG), 1};

    // Reset held 3 cycles with in_we high.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, mk(9, 9, 7));
      chk("rst_plot", 32'(plot), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_xyc", {14'd0, x, y, colour}, 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, '0);
      chk("post_rst_plot", 32'(plot), 0);
    end

    for (int i = 0; i < 12; i++) begin
      step(0, tv[i].clr, tv[i].we, tv[i].p);
      chk("tv_plot", 32'(plot), 32'(tv[i].e_plot));
      chk("tv_busy", 32'(busy), 32'(tv[i].e_busy));
      if (tv[i].e_plot) chk("tv_pix", 32'(mk(int'(x), int'(y), int'(colour))), 32'(tv[i].e_pix));
    end
    idle(15);
    chk("tv_ovf", 32'(overflow), 0);

    // Queue A,B,C during the sweep: they follow the last clear pixel with no gap.
    clear_got();
    cstep(1, 0, '0);
    cstep(0, 0, '0);
    cstep(0, 1, mk(50, 60, 2));
    cstep(0, 1, mk(51, 61, 3));
    cstep(0, 1, mk(52, 62, 6));
    for (int i = 0; i < 20; i++) cstep(0, 0, '0);
    expq.delete();
    add_sweep(expq);
    expq.push_back(mk(50, 60, 2));
    expq.push_back(mk(51, 61, 3));
    expq.push_back(mk(52, 62, 6));
    chk_seq("abc", expq);
    chk("abc_span", 32'(got_last - got_first + 1), 32'(W * H + 3));
    chk("abc_busy", 32'(got_busy), 32'(W * H));
    chk("abc_first_lat", 32'(got_first - (cyc - 24)), 2);

    // Five pushes into a 4-deep FIFO during a sweep.
    clear_got();
    cstep(1, 0, '0);
    for (int i = 0; i < 5; i++) cstep(0, 1, mk(100 + i, 40 + i, i));
    for (int i = 0; i < 20; i++) cstep(0, 0, '0);
    expq.delete();
    add_sweep(expq);
    for (int i = 0; i < 4; i++) expq.push_back(mk(100 + i, 40 + i, i));
    chk_seq("ovf", expq);
    chk("ovf_flag", 32'(overflow), 1);
    idle(10);
    chk("ovf_sticky", 32'(overflow), 1);

    // Restart mid-sweep: queued pixels are flushed, sweep starts again.
    cstep(1, 0, '0);
    cstep(0, 1, mk(70, 70, 7));
    cstep(0, 1, mk(71, 71, 7));
    cstep(0, 0, '0);
    cstep(0, 0, '0);
    cstep(1, 0, '0);
    clear_got();
    for (int i = 0; i < 25; i++) cstep(0, 0, '0);
    expq.delete();
    add_sweep(expq);
    chk_seq("restart", expq);
    chk("restart_first", 32'(got_first - (cyc - 25)), 2);
    chk("restart_ovf", 32'(overflow), 1);

    // Randomized traffic against the model.
    step(1, 0, 0, '0);
    for (int i = 0; i < 3000; i++) begin
      logic r, cl, we;
      r  = ($urandom_range(0, 599) == 0);
      cl = ($urandom_range(0, 39) == 0);
      we = ($urandom_range(0, 1) == 1);
      step(r, cl, we, mk($urandom_range(0, 180), $urandom_range(0, 127), $urandom_range(0, 7)));
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
